// File: rtl/abacbd_sweep_checker.sv
// -----------------------------------------------------------------------------
// abacbd_sweep_checker
//
// Drives all 16 input combinations into an abacbd complex gate
// (f = ~(a&b | a&c | b&d)). Each vector is held for SETTLE_CYCLES clocks. On
// the last clock of that hold, the gate output f_i is sampled and compared
// against the golden function. The checker records the measured truth table,
// the number of mismatches and the first failing vector. At the end of a
// sweep it pulses done and reports pass.
//
// Parameters
//   SETTLE_CYCLES   clocks each vector is held before f_i is sampled (1..15)
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous, active-high reset (highest priority)
//   start            begin a sweep; accepted only when idle and abort is low
//   abort            cancel a running sweep; partial results are kept
//   f_i              output of the gate under test
//   a_o..d_o         gate inputs, vector bits 3..0, driven straight from flops
//   busy             sweep in progress
//   done             one-cycle pulse when a sweep completes
//   pass             last completed sweep had zero mismatches
//   err_count        mismatches in the last sweep (0..16)
//   first_err_vec    first failing vector {a,b,c,d}
//   first_err_valid  first_err_vec holds a valid value
//   truth_tbl        bit i = sampled f for vector i
// -----------------------------------------------------------------------------
module abacbd_sweep_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        f_i,
   output logic        a_o,
   output logic        b_o,
   output logic        c_o,
   output logic        d_o,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [4:0]  err_count,
   output logic [3:0]  first_err_vec,
   output logic        first_err_valid,
   output logic [15:0] truth_tbl
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   // Value of the settle counter on the clock where the vector is sampled.
   localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

   // Reference behaviour of a fault-free abacbd gate.
   function automatic logic golden_f(input logic [3:0] v);
      return ~((v[3] & v[2]) | (v[3] & v[1]) | (v[2] & v[0]));
   endfunction

   state_t      r_state;
   logic [3:0]  r_vec;
   logic [3:0]  r_cnt;
   logic        r_busy;
   logic        r_done;
   logic        r_pass;
   logic [4:0]  r_err_count;
   logic [3:0]  r_first_err_vec;
   logic        r_first_err_valid;
   logic [15:0] r_truth_tbl;

   logic        w_sample;
   logic        w_mismatch;

   assign w_sample   = (r_cnt == CNT_LAST);
   assign w_mismatch = (f_i != golden_f(r_vec));

   // NOTE: every piece of state, including the 16-bit truth table, is written
   // with non-blocking assignments and cleared by reset. The reset is needed
   // because the results must read as zero straight after rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state           <= ST_IDLE;
         r_vec             <= '0;
         r_cnt             <= '0;
         r_busy            <= 1'b0;
         r_done            <= 1'b0;
         r_pass            <= 1'b0;
         r_err_count       <= '0;
         r_first_err_vec   <= '0;
         r_first_err_valid <= 1'b0;
         r_truth_tbl       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_done <= 1'b0;
               // abort wins over a simultaneous start
               if (start && !abort) begin
                  r_vec             <= '0;
                  r_cnt             <= '0;
                  r_busy            <= 1'b1;
                  r_pass            <= 1'b0;
                  r_err_count       <= '0;
                  r_first_err_valid <= 1'b0;
                  r_truth_tbl       <= '0;
                  r_state           <= ST_SETTLE;
               end
            end

            ST_SETTLE: begin
               if (abort) begin
                  // Partial truth table and error info stay visible.
                  r_vec   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_pass  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (!w_sample) begin
                  r_cnt <= r_cnt + 4'd1;
               end else begin
                  r_truth_tbl[r_vec] <= f_i;
                  if (w_mismatch) begin
                     // At most 16 samples per sweep, so 5 bits never wrap.
                     r_err_count <= r_err_count + 5'd1;
                     if (!r_first_err_valid) begin
                        r_first_err_vec   <= r_vec;
                        r_first_err_valid <= 1'b1;
                     end
                  end
                  if (r_vec == 4'hF) begin
                     r_vec   <= '0;
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_vec <= r_vec + 4'd1;
                     r_cnt <= '0;
                  end
               end
            end

            ST_DONE: begin
               // r_err_count already includes the vector-15 result here.
               r_done  <= 1'b1;
               r_pass  <= (r_err_count == 5'd0);
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A zero settle interval has no defined behaviour; flag it in simulation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (SETTLE_CYCLES != 0 && SETTLE_CYCLES <= 15)
            else $error("abacbd_sweep_checker: SETTLE_CYCLES must be 1..15");
      end
   end

   assign a_o             = r_vec[3];
   assign b_o             = r_vec[2];
   assign c_o             = r_vec[1];
   assign d_o             = r_vec[0];
   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign err_count       = r_err_count;
   assign first_err_vec   = r_first_err_vec;
   assign first_err_valid = r_first_err_valid;
   assign truth_tbl       = r_truth_tbl;

endmodule
